pio_bus_sequencer: RTL and testbench

PIO_BUS_SEQUENCER -- requirements
Module: pio_bus_sequencer

---
 rtl/pio_bus_sequencer.sv | 150 +++++++++++++++
 tb/tb_pio_bus_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pio_bus_sequencer.sv
// PIO bus cycle sequencer: decodes a strobed access into a one-hot slot enable,
// inserts per-region wait states and optional ready stalls, then acks or bus-errors.
module pio_bus_sequencer #(
    parameter int unsigned MAJOR_W = 3,
    parameter int unsigned MINOR_W = 2,
    parameter int unsigned WS_W    = 4,
    parameter logic [(2**MAJOR_W)*WS_W-1:0]         WAIT_STATES = '0,
    parameter logic [(2**(MAJOR_W+MINOR_W))-1:0]    READY_MASK  = '0,
    parameter logic [(2**MAJOR_W)-1:0]              UNMAP_MASK  = 8'hF0,
    parameter int unsigned TO_W    = 6
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 cs,
    input  logic                                 as_n,
    input  logic                                 rw_n,
    input  logic [MAJOR_W-1:0]                   adm,
    input  logic [MINOR_W-1:0]                   adl,
    input  logic [(2**(MAJOR_W+MINOR_W))-1:0]    rdy,
    output logic [(2**(MAJOR_W+MINOR_W))-1:0]    sel,
    output logic                                 rd_en,
    output logic                                 wr_pulse,
    output logic                                 dtack_n,
    output logic                                 berr_n,
    output logic                                 busy
);

    localparam int unsigned NMAJ   = 2**MAJOR_W;
    localparam int unsigned SLOT_W = MAJOR_W + MINOR_W;
    localparam int unsigned NSLOT  = 2**SLOT_W;
    // Last timeout count before the limit; crossing it ends the cycle in BERR.
    localparam logic [TO_W-1:0] TO_PRE = {{(TO_W-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {IDLE, STROBE, ACK, BERR} state_t;

    state_t              state;
    logic [SLOT_W-1:0]   slot_q;
    logic                rw_q;
    logic [WS_W-1:0]     wcnt;
    logic [TO_W-1:0]     tcnt;
    logic                first_q;
    logic                armed_q;

    logic [SLOT_W-1:0]   slot_c;
    logic [WS_W-1:0]     ws_c;
    logic                ready_ok_c;
    logic                start_c;

    // Region wait-state lookup from the live address, used only at the sampling edge.
    always_comb begin
        ws_c = '0;
        for (int unsigned r = 0; r < NMAJ; r++) begin
            if (adm == MAJOR_W'(r)) begin
                ws_c = WAIT_STATES[r*WS_W +: WS_W];
            end
        end
    end

    assign slot_c     = {adm, adl};
    assign ready_ok_c = !READY_MASK[slot_q] || rdy[slot_q];
    assign start_c    = cs && !as_n && armed_q;

    // First STROBE cycle is an address setup cycle; wait states count after it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            slot_q   <= '0;
            rw_q     <= 1'b1;
            wcnt     <= '0;
            tcnt     <= '0;
            first_q  <= 1'b0;
            armed_q  <= 1'b0;
            sel      <= '0;
            rd_en    <= 1'b0;
            wr_pulse <= 1'b0;
            dtack_n  <= 1'b1;
            berr_n   <= 1'b1;
            busy     <= 1'b0;
        end else begin
            if (as_n) begin
                armed_q <= 1'b1;
            end
            if (state != IDLE && as_n) begin
                state    <= IDLE;
                wcnt     <= '0;
                tcnt     <= '0;
                first_q  <= 1'b0;
                sel      <= '0;
                rd_en    <= 1'b0;
                wr_pulse <= 1'b0;
                dtack_n  <= 1'b1;
                berr_n   <= 1'b1;
                busy     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_c) begin
                            slot_q <= slot_c;
                            rw_q   <= rw_n;
                            busy   <= 1'b1;
                            if (UNMAP_MASK[adm]) begin
                                state  <= BERR;
                                berr_n <= 1'b0;
                            end else begin
                                state   <= STROBE;
                                sel     <= NSLOT'(1) << slot_c;
                                rd_en   <= rw_n;
                                wcnt    <= ws_c;
                                tcnt    <= '0;
                                first_q <= 1'b1;
                            end
                        end
                    end
                    STROBE: begin
                        if (first_q) begin
                            first_q <= 1'b0;
                            tcnt    <= tcnt + TO_W'(1);
                        end else if (wcnt == '0 && ready_ok_c) begin
                            state    <= ACK;
                            dtack_n  <= 1'b0;
                            wr_pulse <= !rw_q;
                        end else if (tcnt == TO_PRE) begin
                            state  <= BERR;
                            berr_n <= 1'b0;
                            sel    <= '0;
                            rd_en  <= 1'b0;
                        end else begin
                            if (wcnt != '0) begin
                                wcnt <= wcnt - WS_W'(1);
                            end
                            tcnt <= tcnt + TO_W'(1);
                        end
                    end
                    ACK: begin
                        wr_pulse <= 1'b0;
                    end
                    BERR: begin
                        sel      <= '0;
                        rd_en    <= 1'b0;
                        wr_pulse <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pio_bus_sequencer.sv
// Randomized bench for pio_bus_sequencer; expected waveforms come from a
// per-transaction timing model (terminal edge and release edge arithmetic).
module tb_pio_bus_sequencer;

    localparam logic [31:0] WS_P    = 32'h2222_5103;
    localparam logic [31:0] RDY_P   = 32'h0000_2010;
    localparam logic [7:0]  UNMAP_P = 8'hF0;

    logic        clk;
    logic        reset_n;
    logic        cs;
    logic        as_n;
    logic        rw_n;
    logic [2:0]  adm;
    logic [1:0]  adl;
    logic [31:0] rdy;
    logic [31:0] sel;
    logic        rd_en;
    logic        wr_pulse;
    logic        dtack_n;
    logic        berr_n;
    logic        busy;

    int checks = 0;
    int errors = 0;

    int ws_tab [8] = '{3, 0, 1, 5, 2, 2, 2, 2};

    logic [36:0] obs;
    assign obs = {sel, rd_en, wr_pulse, dtack_n, berr_n, busy};

    localparam logic [36:0] IDLE_V = {32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    pio_bus_sequencer #(
        .MAJOR_W    (3),
        .MINOR_W    (2),
        .WS_W       (4),
        .WAIT_STATES(WS_P),
        .READY_MASK (RDY_P),
        .UNMAP_MASK (UNMAP_P),
        .TO_W       (6)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .cs      (cs),
        .as_n    (as_n),
        .rw_n    (rw_n),
        .adm     (adm),
        .adl     (adl),
        .rdy     (rdy),
        .sel     (sel),
        .rd_en   (rd_en),
        .wr_pulse(wr_pulse),
        .dtack_n (dtack_n),
        .berr_n  (berr_n),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic scramble_idle_inputs();
        adm  = 3'($urandom);
        adl  = 2'($urandom);
        rw_n = 1'($urandom);
        rdy  = $urandom;
    endtask

    // Idle cycles: as_n may fall but cs is kept low, so nothing may start.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            as_n = 1'($urandom);
            cs   = as_n ? 1'($urandom) : 1'b0;
            scramble_idle_inputs();
            @(posedge clk); #1;
            check("idle", 64'(obs), 64'(IDLE_V));
        end
        as_n = 1'b1;
        cs   = 1'b1;
    endtask

    // abort_at: -1 none, -2 random point before termination, >=0 fixed edge.
    task automatic run_txn(input int m, input int l, input logic rw, input int rd_delay,
                           input int abort_at, input int hold);
        int          slot;
        int          t;
        int          rel;
        int          r_edge;
        bit          mapped;
        bit          gated;
        bit          ack;
        logic [31:0] onehot;
        logic [31:0] e_sel;
        logic        e_rd;
        logic        e_wr;
        logic        e_dt;
        logic        e_be;
        logic        e_bu;
        slot   = m * 4 + l;
        mapped = (m < 4);
        gated  = (slot == 4) || (slot == 13);
        ack    = 1'b0;
        if (!mapped) begin
            t = 0;
        end else begin
            t = ws_tab[m] + 2;
            if (gated && rd_delay + 1 > t) t = rd_delay + 1;
            if (t > 63) t = 63;
            else        ack = 1'b1;
        end
        if (mapped && abort_at == -2)      rel = $urandom_range(0, t - 1);
        else if (mapped && abort_at >= 0)  rel = abort_at;
        else                               rel = t + hold;
        r_edge = rel + 1;
        onehot = 32'd1 << slot;

        adm  = 3'(m);
        adl  = 2'(l);
        rw_n = rw;
        cs   = 1'b1;
        as_n = 1'b0;
        rdy  = $urandom;
        if (gated) rdy[slot] = 1'b0;
        for (int k = 0; k <= r_edge; k++) begin
            @(posedge clk); #1;
            e_bu  = (k < r_edge);
            e_sel = (mapped && k < r_edge && (ack || k < t)) ? onehot : 32'h0;
            e_rd  = (mapped && k < r_edge && (ack || k < t)) ? rw : 1'b0;
            e_dt  = !(ack && k >= t && k < r_edge);
            e_be  = !(!ack && k >= t && k < r_edge);
            e_wr  = ack && !rw && k == t && t < r_edge;
            check($sformatf("txn m%0d l%0d rw%0d k%0d", m, l, rw, k), 64'(obs),
                  64'({e_sel, e_rd, e_wr, e_dt, e_be, e_bu}));
            if (k == rel) as_n = 1'b1;
            scramble_idle_inputs();
            cs = 1'($urandom);
            if (gated) rdy[slot] = (k >= rd_delay);
        end
        cs = 1'b1;
    endtask

    task automatic reset_mid_write();
        adm  = 3'd0;
        adl  = 2'd2;
        rw_n = 1'b0;
        cs   = 1'b1;
        as_n = 1'b0;
        rdy  = 32'h0;
        for (int k = 0; k <= 5; k++) begin
            @(posedge clk); #1;
        end
        check("rst_pre_ack", 64'(obs), 64'({32'h4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1}));
        #2 reset_n = 1'b0;
        #1 check("rst_async", 64'(obs), 64'(IDLE_V));
        #2 reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("rst_no_restart", 64'(obs), 64'(IDLE_V));
        end
        as_n = 1'b1;
        @(posedge clk); #1;
        check("rst_idle", 64'(obs), 64'(IDLE_V));
    endtask

    initial begin
        reset_n = 1'b0;
        cs      = 1'b0;
        as_n    = 1'b1;
        rw_n    = 1'b1;
        adm     = 3'd0;
        adl     = 2'd0;
        rdy     = 32'h0;
        #12;
        check("reset", 64'(obs), 64'(IDLE_V));
        #5 reset_n = 1'b1;
        idle_cycles(3);

        run_txn(1, 1, 1'b1, 0, -1, 1);      // plain read, zero wait
        run_txn(0, 2, 1'b0, 0, -1, 2);      // 3 wait-state write
        run_txn(1, 0, 1'b1, 10, -1, 1);     // ready stall of 10 cycles
        run_txn(1, 0, 1'b0, 1000, -1, 2);   // ready never rises: timeout
        run_txn(5, 3, 1'b1, 0, -1, 3);      // unmapped region
        run_txn(0, 1, 1'b0, 0, 3, 0);       // released during wait states
        idle_cycles(2);
        reset_mid_write();

        for (int i = 0; i < 40; i++) begin
            int   m;
            int   l;
            int   rd;
            int   ab;
            logic rw;
            m  = $urandom_range(0, 7);
            l  = $urandom_range(0, 3);
            rw = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                m = ($urandom_range(0, 1) != 0) ? 1 : 3;
                l = (m == 1) ? 0 : 1;
            end
            rd = ($urandom_range(0, 7) == 0) ? 200 : $urandom_range(0, 20);
            ab = ($urandom_range(0, 3) == 0) ? -2 : -1;
            run_txn(m, l, rw, rd, ab, $urandom_range(0, 3));
            if ($urandom_range(0, 1) != 0) idle_cycles($urandom_range(1, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
